// File: rtl/lcd_bus_receiver.sv
// rtl/lcd_bus_receiver.sv - passive HD44780 8-bit write-bus decoder keeping a 2x16 character shadow.
// Short-strobe rejection (MIN_E_HIGH, glitch) is built only when LCD_RX_GLITCH_FILTER_EN is defined.
module lcd_bus_receiver #(
   parameter int MIN_E_HIGH = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_char,
   output logic [6:0] cur_addr,
   output logic [7:0] last_cmd,
   output logic       wr_strobe,
   output logic       cmd_strobe,
   output logic       rw_seen,
   output logic       overrun,
   output logic       glitch,
   output logic       clearing
);

   typedef enum logic [1:0] {CLEAR, IDLE, E_HIGH, COMMIT} state_t;

`ifdef LCD_RX_GLITCH_FILTER_EN
   localparam logic [3:0] MIN_COUNT = (MIN_E_HIGH < 1)  ? 4'd1  :
                                      (MIN_E_HIGH > 15) ? 4'd15 : 4'(MIN_E_HIGH);
`else
   // Unfiltered: a single synchronized high cycle always qualifies, whatever MIN_E_HIGH is.
   localparam logic [3:0] MIN_COUNT = (MIN_E_HIGH > 0) ? 4'd1 : 4'd1;
`endif

   state_t      state, next_state;
   logic [10:0] sync1, sync2;
   logic        e_s, rs_s, rw_s;
   logic [7:0]  data_s;
   logic        e_prev;
   logic        hold_rs, hold_rw;
   logic [7:0]  hold_data;
   logic [3:0]  e_count;
   logic [4:0]  clr_idx;
   logic        inc_mode, cgram_mode;
   logic [7:0]  shadow [32];

   logic        capture, load_count, do_commit, do_glitch, drop, is_clear_cmd;
   logic        shadow_we;
   logic [4:0]  shadow_idx;
   logic [7:0]  shadow_wdata;

   assign e_s    = sync2[10];
   assign rs_s   = sync2[9];
   assign rw_s   = sync2[8];
   assign data_s = sync2[7:0];

   assign clearing     = (state == CLEAR);
   assign is_clear_cmd = !hold_rw && !hold_rs && (hold_data == 8'h01);

   function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
      if (up) begin
         if (a == 7'h27) return 7'h40;
         if (a == 7'h67) return 7'h00;
         return a + 7'd1;
      end
      if (a == 7'h00) return 7'h67;
      if (a == 7'h40) return 7'h27;
      return a - 7'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         state <= CLEAR;
      end else begin
         sync1 <= {lcd_e, lcd_rs, lcd_rw, lcd_data};
         sync2 <= sync1;
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      capture    = 1'b0;
      load_count = 1'b0;
      do_commit  = 1'b0;
      do_glitch  = 1'b0;
      drop       = 1'b0;
      case (state)
         CLEAR: begin
            drop = e_prev && !e_s;
            if (clr_idx == 5'd31) next_state = IDLE;
         end
         IDLE: begin
            if (e_s) begin
               next_state = E_HIGH;
               capture    = 1'b1;
               load_count = 1'b1;
            end
         end
         E_HIGH: begin
            if (e_s) begin
               capture = 1'b1;
            end else if (e_count >= MIN_COUNT) begin
               next_state = COMMIT;
            end else begin
               next_state = IDLE;
               do_glitch  = 1'b1;
            end
         end
         COMMIT: begin
            do_commit = 1'b1;
            if (is_clear_cmd) begin
               next_state = CLEAR;
            end else if (e_s) begin
               next_state = E_HIGH;
               capture    = 1'b1;
               load_count = 1'b1;
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = CLEAR;
      endcase
   end

   // Single write port shared by the clear sweep and DDRAM data commits; never both at once.
   always_comb begin
      shadow_we    = 1'b0;
      shadow_idx   = clr_idx;
      shadow_wdata = 8'h20;
      if (state == CLEAR) begin
         shadow_we = 1'b1;
      end else if (do_commit && !hold_rw && hold_rs && !cgram_mode) begin
         shadow_wdata = hold_data;
         if (cur_addr[6:4] == 3'b000) begin
            shadow_we  = 1'b1;
            shadow_idx = {1'b0, cur_addr[3:0]};
         end else if (cur_addr[6:4] == 3'b100) begin
            shadow_we  = 1'b1;
            shadow_idx = {1'b1, cur_addr[3:0]};
         end
      end
      if (reset) shadow_we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (shadow_we) shadow[shadow_idx] <= shadow_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_prev     <= 1'b0;
         hold_rs    <= 1'b0;
         hold_rw    <= 1'b0;
         hold_data  <= 8'h00;
         e_count    <= 4'd0;
         clr_idx    <= 5'd0;
         cur_addr   <= 7'h00;
         inc_mode   <= 1'b1;
         cgram_mode <= 1'b0;
         last_cmd   <= 8'h00;
         wr_strobe  <= 1'b0;
         cmd_strobe <= 1'b0;
         rw_seen    <= 1'b0;
         overrun    <= 1'b0;
         glitch     <= 1'b0;
         rd_char    <= 8'h00;
      end else begin
         e_prev     <= e_s;
         rd_char    <= shadow[rd_addr];
         wr_strobe  <= 1'b0;
         cmd_strobe <= 1'b0;
         rw_seen    <= 1'b0;
         glitch     <= do_glitch;
         if (drop) overrun <= 1'b1;
         clr_idx <= (state == CLEAR) ? clr_idx + 5'd1 : 5'd0;

         if (capture) begin
            hold_rs   <= rs_s;
            hold_rw   <= rw_s;
            hold_data <= data_s;
         end
         if (load_count)                     e_count <= 4'd1;
         else if (capture && e_count != 4'hF) e_count <= e_count + 4'd1;

         if (do_commit) begin
            if (hold_rw) begin
               rw_seen <= 1'b1;
            end else if (hold_rs) begin
               wr_strobe <= 1'b1;
               if (!cgram_mode) cur_addr <= step_addr(cur_addr, inc_mode);
            end else begin
               last_cmd   <= hold_data;
               cmd_strobe <= 1'b1;
               if (hold_data[7]) begin
                  cur_addr   <= hold_data[6:0];
                  cgram_mode <= 1'b0;
               end else if (hold_data[6]) begin
                  cgram_mode <= 1'b1;
               end else if (hold_data[5:3] == 3'b000) begin
                  if (hold_data[2]) begin
                     inc_mode <= hold_data[1];
                  end else if (hold_data[1]) begin
                     cur_addr   <= 7'h00;
                     cgram_mode <= 1'b0;
                  end else if (hold_data[0]) begin
                     cur_addr   <= 7'h00;
                     inc_mode   <= 1'b1;
                     cgram_mode <= 1'b0;
                  end
               end
            end
         end
      end
   end

endmodule
